// File: rtl/skintone_result_packer.sv
// Packs four 8-bit skin-tone results into little-endian 32-bit words, flushing a zero-padded partial word at frame end.
// Word valid one cycle after its completing byte; single registered output slot, input stalls only when a completing byte meets a blocked word.
module skintone_result_packer #(
    parameter int FRAME_PIXELS = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  result_datain,
    input  logic        result_datain_valid,
    output logic        result_datain_ready,
    output logic [31:0] word_dataout,
    output logic        word_dataout_valid,
    input  logic        word_dataout_ready,
    output logic [3:0]  word_dataout_keep,
    output logic        word_dataout_last
);

    localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0] PIX_ONE  = CW'(1);

    logic [23:0]   acc;
    logic [1:0]    byte_idx;
    logic [CW-1:0] pix_cnt;

    logic          frame_end;
    logic          completing;
    logic          in_fire;
    logic          out_fire;
    logic          load;
    logic [31:0]   word_next;
    logic [3:0]    keep_next;

    assign frame_end  = (pix_cnt == LAST_PIX);
    assign completing = (byte_idx == 2'd3) || frame_end;

    // A completing byte may land only if the output slot is free or drains this same cycle.
    assign result_datain_ready = !rst && (!completing || !word_dataout_valid || word_dataout_ready);

    assign in_fire  = result_datain_valid && result_datain_ready;
    assign out_fire = word_dataout_valid && word_dataout_ready;
    assign load     = in_fire && completing;

    always_comb begin
        word_next = 32'h0;
        keep_next = 4'b0001;
        case (byte_idx)
            2'd0: begin
                word_next = {24'h0, result_datain};
                keep_next = 4'b0001;
            end
            2'd1: begin
                word_next = {16'h0, result_datain, acc[7:0]};
                keep_next = 4'b0011;
            end
            2'd2: begin
                word_next = {8'h0, result_datain, acc[15:0]};
                keep_next = 4'b0111;
            end
            default: begin
                word_next = {result_datain, acc};
                keep_next = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= 24'h0;
            byte_idx <= 2'd0;
            pix_cnt  <= '0;
        end else if (in_fire) begin
            if (completing) begin
                acc      <= 24'h0;
                byte_idx <= 2'd0;
                pix_cnt  <= frame_end ? '0 : pix_cnt + PIX_ONE;
            end else begin
                case (byte_idx)
                    2'd0:    acc[7:0]   <= result_datain;
                    2'd1:    acc[15:8]  <= result_datain;
                    default: acc[23:16] <= result_datain;
                endcase
                byte_idx <= byte_idx + 2'd1;
                pix_cnt  <= pix_cnt + PIX_ONE;
            end
        end
    end

    // Reload beats drain, so a same-cycle swap keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_dataout       <= 32'h0;
            word_dataout_keep  <= 4'h0;
            word_dataout_last  <= 1'b0;
            word_dataout_valid <= 1'b0;
        end else if (load) begin
            word_dataout       <= word_next;
            word_dataout_keep  <= keep_next;
            word_dataout_last  <= frame_end;
            word_dataout_valid <= 1'b1;
        end else if (out_fire) begin
            word_dataout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_skintone_result_packer.sv
// Directed bench for skintone_result_packer: four instances at FRAME_PIXELS 6, 8, 1 and 7 share clock and reset.
module tb_skintone_result_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  din  [4];
    logic        dvld [4];
    logic        rdy  [4];
    logic [31:0] word [4];
    logic        wvld [4];
    logic        wrdy [4];
    logic [3:0]  keep [4];
    logic        last [4];

    int tests = 0;
    int fails = 0;

    skintone_result_packer #(.FRAME_PIXELS(6)) u_fp6 (
        .clk(clk), .rst(rst),
        .result_datain(din[0]), .result_datain_valid(dvld[0]), .result_datain_ready(rdy[0]),
        .word_dataout(word[0]), .word_dataout_valid(wvld[0]), .word_dataout_ready(wrdy[0]),
        .word_dataout_keep(keep[0]), .word_dataout_last(last[0])
    );
    skintone_result_packer #(.FRAME_PIXELS(8)) u_fp8 (
        .clk(clk), .rst(rst),
        .result_datain(din[1]), .result_datain_valid(dvld[1]), .result_datain_ready(rdy[1]),
        .word_dataout(word[1]), .word_dataout_valid(wvld[1]), .word_dataout_ready(wrdy[1]),
        .word_dataout_keep(keep[1]), .word_dataout_last(last[1])
    );
    skintone_result_packer #(.FRAME_PIXELS(1)) u_fp1 (
        .clk(clk), .rst(rst),
        .result_datain(din[2]), .result_datain_valid(dvld[2]), .result_datain_ready(rdy[2]),
        .word_dataout(word[2]), .word_dataout_valid(wvld[2]), .word_dataout_ready(wrdy[2]),
        .word_dataout_keep(keep[2]), .word_dataout_last(last[2])
    );
    skintone_result_packer #(.FRAME_PIXELS(7)) u_fp7 (
        .clk(clk), .rst(rst),
        .result_datain(din[3]), .result_datain_valid(dvld[3]), .result_datain_ready(rdy[3]),
        .word_dataout(word[3]), .word_dataout_valid(wvld[3]), .word_dataout_ready(wrdy[3]),
        .word_dataout_keep(keep[3]), .word_dataout_last(last[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compares {valid, last, keep, word} of one instance as a single value.
    task automatic chk_out(input string tag, input int id, input logic v, input logic l,
                           input logic [3:0] k, input logic [31:0] w);
        chk(tag, 64'({wvld[id], last[id], keep[id], word[id]}), 64'({v, l, k, w}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame of 0x01..0x06 into the FRAME_PIXELS=6 instance, downstream always ready.
    task automatic frame6(input string tag);
        for (int i = 1; i <= 6; i++) begin
            din[0] = 8'(i); dvld[0] = 1'b1; wrdy[0] = 1'b1;
            #1;
            chk({tag, " rdy"}, 64'(rdy[0]), 64'(1));
            tick();
            if (i == 4) chk_out({tag, " word0"}, 0, 1'b1, 1'b0, 4'hF, 32'h04030201);
            if (i == 5) chk({tag, " drained"}, 64'(wvld[0]), 64'(0));
            if (i == 6) chk_out({tag, " word1"}, 0, 1'b1, 1'b1, 4'h3, 32'h00000605);
        end
        dvld[0] = 1'b0;
    endtask

    logic [36:0] expq [$];
    logic [31:0] m_word;
    logic [3:0]  m_keep;
    int          m_lane, m_pix;
    int          acc_bytes, nwords, nlast, cyc;
    bit          have_byte, stall_prev, m_last;
    logic [7:0]  cur;
    logic [36:0] prev_out;
    logic [7:0]  fp1_bytes [3];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00; dvld[i] = 1'b0; wrdy[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("reset out %0d", i), i, 1'b0, 1'b0, 4'h0, 32'h0);
            chk($sformatf("reset rdy %0d", i), 64'(rdy[i]), 64'(0));
        end
        rst = 1'b0;
        #1;
        chk("rdy after release", 64'(rdy[0]), 64'(1));

        // Partial final word with zero padding.
        frame6("fp6");
        wrdy[0] = 1'b1;
        tick();

        // Two back-to-back frames, no bubble at the wrap.
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 8; j++) begin
                din[1] = 8'hA0 + 8'(j); dvld[1] = 1'b1; wrdy[1] = 1'b1;
                #1;
                chk($sformatf("fp8 rdy f%0d b%0d", f, j), 64'(rdy[1]), 64'(1));
                tick();
                if (j == 3) chk_out($sformatf("fp8 w0 f%0d", f), 1, 1'b1, 1'b0, 4'hF, 32'hA3A2A1A0);
                if (j == 7) chk_out($sformatf("fp8 w1 f%0d", f), 1, 1'b1, 1'b1, 4'hF, 32'hA7A6A5A4);
            end
        end
        dvld[1] = 1'b0;
        tick();
        chk("fp8 drained", 64'(wvld[1]), 64'(0));

        // Backpressure: downstream blocked for 10 cycles after the first word.
        for (int j = 0; j < 4; j++) begin
            din[1] = 8'h10 + 8'(j); dvld[1] = 1'b1; wrdy[1] = 1'b1;
            tick();
        end
        chk_out("bp first word", 1, 1'b1, 1'b0, 4'hF, 32'h13121110);
        for (int c = 0; c < 10; c++) begin
            wrdy[1] = 1'b0;
            din[1]  = (c < 3) ? 8'h14 + 8'(c) : 8'h17;
            dvld[1] = 1'b1;
            #1;
            chk($sformatf("bp rdy c%0d", c), 64'(rdy[1]), 64'(c < 3));
            chk_out($sformatf("bp hold c%0d", c), 1, 1'b1, 1'b0, 4'hF, 32'h13121110);
            tick();
        end
        wrdy[1] = 1'b1; din[1] = 8'h17; dvld[1] = 1'b1;
        #1;
        chk("bp rdy recover", 64'(rdy[1]), 64'(1));
        tick();
        chk_out("bp second word", 1, 1'b1, 1'b1, 4'hF, 32'h17161514);
        dvld[1] = 1'b0;
        tick();
        chk("bp drained", 64'(wvld[1]), 64'(0));

        // One-pixel frames: every byte is its own last word.
        fp1_bytes[0] = 8'hFF; fp1_bytes[1] = 8'h00; fp1_bytes[2] = 8'h7E;
        for (int k = 0; k < 3; k++) begin
            din[2] = fp1_bytes[k]; dvld[2] = 1'b1; wrdy[2] = 1'b1;
            tick();
            chk_out($sformatf("fp1 word %0d", k), 2, 1'b1, 1'b1, 4'h1, {24'h0, fp1_bytes[k]});
        end
        dvld[2] = 1'b0;
        tick();

        // Reset in the middle of a frame discards the partial word.
        wrdy[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            din[0] = 8'(k * 8'h11); dvld[0] = 1'b1;
            tick();
        end
        dvld[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid rst valid", 64'(wvld[0]), 64'(0));
        chk("mid rst rdy", 64'(rdy[0]), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("post rst valid", 64'(wvld[0]), 64'(0));
        frame6("after rst");
        wrdy[0] = 1'b1;
        tick();

        // Random valid/ready against a byte-level scoreboard, 1000 frames of 7.
        m_word = 32'h0; m_keep = 4'h0; m_lane = 0; m_pix = 0;
        acc_bytes = 0; nwords = 0; nlast = 0; cyc = 0;
        have_byte = 1'b0; stall_prev = 1'b0; prev_out = '0; cur = 8'h00;
        while ((acc_bytes < 7000 || expq.size() != 0) && cyc < 40000) begin
            if (!have_byte) begin
                cur = 8'($urandom);
                have_byte = 1'b1;
            end
            din[3]  = cur;
            dvld[3] = (acc_bytes < 7000) && ($urandom_range(0, 3) != 0);
            wrdy[3] = ($urandom_range(0, 2) != 0);
            #1;
            if (stall_prev)
                chk("rnd stall hold", 64'({wvld[3], last[3], keep[3], word[3]}), 64'({1'b1, prev_out}));
            if (wvld[3] && wrdy[3]) begin
                chk($sformatf("rnd word %0d", nwords), 64'({last[3], keep[3], word[3]}),
                    64'((expq.size() != 0) ? expq.pop_front() : 37'h0));
                nwords++;
                if (last[3]) nlast++;
            end
            stall_prev = wvld[3] && !wrdy[3];
            prev_out   = {last[3], keep[3], word[3]};
            if (dvld[3] && rdy[3]) begin
                m_word[8*m_lane +: 8] = cur;
                m_keep[m_lane] = 1'b1;
                if (m_lane == 3 || m_pix == 6) begin
                    m_last = (m_pix == 6);
                    expq.push_back({m_last, m_keep, m_word});
                    m_word = 32'h0; m_keep = 4'h0; m_lane = 0;
                    m_pix = m_last ? 0 : m_pix + 1;
                end else begin
                    m_lane++;
                    m_pix++;
                end
                acc_bytes++;
                have_byte = 1'b0;
            end
            cyc++;
            tick();
        end
        dvld[3] = 1'b0;
        chk("rnd bytes accepted", 64'(acc_bytes), 64'(7000));
        chk("rnd words out", 64'(nwords), 64'(2000));
        chk("rnd last count", 64'(nlast), 64'(1000));
        chk("rnd queue empty", 64'(expq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
